// File: rtl/time_setter.sv
// Time-edit front end for the clock display: captures the live time, lets the
// user step hours and minutes in two-digit BCD, and pulses load on confirm.
module time_setter #(
   parameter int HOUR_MAX = 23,
   parameter int MIN_MAX  = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] en_pause,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [3:0] cur_h1,
   input  logic [3:0] cur_h0,
   input  logic [3:0] cur_m1,
   input  logic [3:0] cur_m0,
   output logic       set,
   output logic [3:0] init_value_h1,
   output logic [3:0] init_value_h0,
   output logic [3:0] init_value_m1,
   output logic [3:0] init_value_m0,
   output logic       load,
   output logic       field
);

   typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_t;

   localparam logic [3:0] H_TENS  = 4'(HOUR_MAX / 10);
   localparam logic [3:0] H_UNITS = 4'(HOUR_MAX % 10);
   localparam logic [3:0] M_TENS  = 4'(MIN_MAX / 10);
   localparam logic [3:0] M_UNITS = 4'(MIN_MAX % 10);

   state_t     state, next_state;
   logic       set_d, load_d, field_d;
   logic [7:0] hour_d, min_d;
   logic       edit_ok, step_inc, step_dec;

   // Increment with wrap; anything at or beyond max (or non-BCD) lands on 00.
   function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] units,
                                          input logic [3:0] max_tens, input logic [3:0] max_units);
      logic below_max;
      below_max = (tens <= 4'd9) && (units <= 4'd9) &&
                  ((tens < max_tens) || ((tens == max_tens) && (units < max_units)));
      if (!below_max)
         return 8'h00;
      if (units == 4'd9)
         return {tens + 4'd1, 4'd0};
      return {tens, units + 4'd1};
   endfunction

   // Decrement with wrap; 00 and any illegal value land on max.
   function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] units,
                                          input logic [3:0] max_tens, input logic [3:0] max_units);
      logic legal;
      legal = (tens <= 4'd9) && (units <= 4'd9) &&
              ((tens < max_tens) || ((tens == max_tens) && (units <= max_units)));
      if (!legal || ((tens == 4'd0) && (units == 4'd0)))
         return {max_tens, max_units};
      if (units == 4'd0)
         return {tens - 4'd1, 4'd9};
      return {tens, units - 4'd1};
   endfunction

   assign edit_ok  = (en_pause == 2'b01);
   // Mode wins over inc/dec, and inc together with dec cancels out.
   assign step_inc = btn_inc & ~btn_dec & ~btn_mode;
   assign step_dec = btn_dec & ~btn_inc & ~btn_mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (btn_mode && edit_ok) next_state = EDIT_H;
         EDIT_H: begin
            if (!edit_ok)      next_state = IDLE;
            else if (btn_mode) next_state = EDIT_M;
         end
         EDIT_M: begin
            if (!edit_ok)      next_state = IDLE;
            else if (btn_mode) next_state = COMMIT;
         end
         COMMIT:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      hour_d  = {init_value_h1, init_value_h0};
      min_d   = {init_value_m1, init_value_m0};
      set_d   = (next_state != IDLE);
      load_d  = (next_state == COMMIT);
      field_d = (next_state == EDIT_M) || (next_state == COMMIT);
      case (state)
         IDLE: begin
            if (btn_mode && edit_ok) begin
               hour_d = {cur_h1, cur_h0};
               min_d  = {cur_m1, cur_m0};
            end
         end
         EDIT_H: begin
            if (edit_ok && step_inc)
               hour_d = bcd_inc(init_value_h1, init_value_h0, H_TENS, H_UNITS);
            else if (edit_ok && step_dec)
               hour_d = bcd_dec(init_value_h1, init_value_h0, H_TENS, H_UNITS);
         end
         EDIT_M: begin
            if (edit_ok && step_inc)
               min_d = bcd_inc(init_value_m1, init_value_m0, M_TENS, M_UNITS);
            else if (edit_ok && step_dec)
               min_d = bcd_dec(init_value_m1, init_value_m0, M_TENS, M_UNITS);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         set           <= 1'b0;
         load          <= 1'b0;
         field         <= 1'b0;
         init_value_h1 <= 4'd0;
         init_value_h0 <= 4'd0;
         init_value_m1 <= 4'd0;
         init_value_m0 <= 4'd0;
      end else begin
         set           <= set_d;
         load          <= load_d;
         field         <= field_d;
         init_value_h1 <= hour_d[7:4];
         init_value_h0 <= hour_d[3:0];
         init_value_m1 <= min_d[7:4];
         init_value_m0 <= min_d[3:0];
      end
   end

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: directed scenarios then random button traffic,
// compared every cycle against an integer-arithmetic model of the editor.
module tb_time_setter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] en_pause;
   logic       btn_mode, btn_inc, btn_dec;
   logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
   logic       set, load, field;
   logic [3:0] init_value_h1, init_value_h0, init_value_m1, init_value_m0;

   int n_tests = 0;
   int n_fail  = 0;

   // model: mode 0=idle 1=edit hour 2=edit minute 3=commit; d = h1,h0,m1,m0
   int ms;
   int d[4];

   time_setter dut (
      .clk(clk), .rst(rst), .en_pause(en_pause),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
      .set(set),
      .init_value_h1(init_value_h1), .init_value_h0(init_value_h0),
      .init_value_m1(init_value_m1), .init_value_m0(init_value_m0),
      .load(load), .field(field)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      ms = 0;
      for (int i = 0; i < 4; i++) d[i] = 0;
   endtask

   task automatic adjust(input bit hour, input bit up);
      int base, mx, v;
      bit legal;
      base  = hour ? 0 : 2;
      mx    = hour ? 23 : 59;
      v     = d[base] * 10 + d[base+1];
      legal = (d[base] <= 9) && (d[base+1] <= 9) && (v <= mx);
      if (up) v = (!legal || v == mx) ? 0 : v + 1;
      else    v = (!legal || v == 0) ? mx : v - 1;
      d[base]   = v / 10;
      d[base+1] = v % 10;
   endtask

   task automatic model_step(input logic [1:0] ep, input logic md, input logic inc, input logic dec);
      case (ms)
         0: if (md && ep == 2'b01) begin
               d[0] = int'(cur_h1); d[1] = int'(cur_h0);
               d[2] = int'(cur_m1); d[3] = int'(cur_m0);
               ms = 1;
            end
         1, 2: begin
            if (ep != 2'b01)      ms = 0;
            else if (md)          ms = ms + 1;
            else if (inc && !dec) adjust(ms == 1, 1'b1);
            else if (dec && !inc) adjust(ms == 1, 1'b0);
         end
         default: ms = 0;
      endcase
   endtask

   task automatic compare_all(input string tag);
      int exp_val;
      exp_val = (d[0] << 12) | (d[1] << 8) | (d[2] << 4) | d[3];
      check({tag, ".set"},   32'(set),   32'(ms != 0));
      check({tag, ".load"},  32'(load),  32'(ms == 3));
      check({tag, ".field"}, 32'(field), 32'(ms == 2 || ms == 3));
      check({tag, ".value"},
            32'({init_value_h1, init_value_h0, init_value_m1, init_value_m0}), 32'(exp_val));
   endtask

   task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
      cur_h1 = 4'(h1); cur_h0 = 4'(h0); cur_m1 = 4'(m1); cur_m0 = 4'(m0);
   endtask

   task automatic step(input string tag, input logic [1:0] ep, input logic md,
                       input logic inc, input logic dec);
      en_pause = ep; btn_mode = md; btn_inc = inc; btn_dec = dec;
      @(posedge clk);
      model_step(ep, md, inc, dec);
      @(negedge clk);
      btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
      compare_all(tag);
   endtask

   // Asserted between clock edges so the clear must come from the async path.
   task automatic async_reset(input string tag);
      #1 rst = 1'b1;
      #1 model_reset();
      compare_all(tag);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en_pause = 2'b01;
      btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
      set_cur(0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      compare_all("reset");
      rst = 1'b0;

      // capture 12:34 and commit
      set_cur(1, 2, 3, 4);
      step("cap_enter",  2'b01, 1, 0, 0);
      step("cap_min",    2'b01, 1, 0, 0);
      step("cap_commit", 2'b01, 1, 0, 0);
      step("cap_idle",   2'b01, 0, 0, 0);
      step("cap_hold",   2'b01, 0, 0, 0);

      // hour wrap from 22
      set_cur(2, 2, 0, 0);
      step("hw_enter", 2'b01, 1, 0, 0);
      step("hw_inc23", 2'b01, 0, 1, 0);
      step("hw_inc00", 2'b01, 0, 1, 0);
      step("hw_dec23", 2'b01, 0, 0, 1);
      step("hw_abort", 2'b10, 0, 0, 0);
      step("hw_after", 2'b10, 0, 0, 0);

      // 09 -> 10, then minute 10 -> 09
      set_cur(0, 9, 1, 0);
      step("h9_enter", 2'b01, 1, 0, 0);
      step("h9_inc",   2'b01, 0, 1, 0);
      step("h9_tomin", 2'b01, 1, 0, 0);
      step("m10_dec",  2'b01, 0, 0, 1);
      step("m_abort",  2'b00, 0, 0, 0);

      // minute wrap from 59
      set_cur(0, 0, 5, 9);
      step("mw_enter", 2'b01, 1, 0, 0);
      step("mw_tomin", 2'b01, 1, 0, 0);
      step("mw_inc00", 2'b01, 0, 1, 0);
      step("mw_dec59", 2'b01, 0, 0, 1);
      async_reset("rst_mid_edit");
      step("rst_after", 2'b01, 0, 0, 0);

      // priority and ignored inputs
      set_cur(1, 5, 4, 4);
      step("idle_pause_mode", 2'b00, 1, 0, 0);
      step("idle_inc",        2'b01, 0, 1, 0);
      step("pr_enter",        2'b01, 1, 0, 0);
      step("pr_incdec",       2'b01, 0, 1, 1);
      step("pr_mode_inc",     2'b01, 1, 1, 0);
      step("pr_abort_mode",   2'b11, 1, 0, 0);

      // out-of-range captured values
      set_cur(2, 5, 6, 15);
      step("oor_enter",  2'b01, 1, 0, 0);
      step("oor_h_inc",  2'b01, 0, 1, 0);
      step("oor_tomin",  2'b01, 1, 0, 0);
      step("oor_m_inc",  2'b01, 0, 1, 0);
      step("oor_abort",  2'b10, 0, 0, 0);
      step("oor2_enter", 2'b01, 1, 0, 0);
      step("oor2_h_dec", 2'b01, 0, 0, 1);
      step("oor2_tomin", 2'b01, 1, 0, 0);
      step("oor2_m_dec", 2'b01, 0, 0, 1);
      step("oor2_commit",2'b10, 1, 0, 0);
      step("oor2_idle",  2'b01, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] ep;
         set_cur($urandom_range(0, 11), $urandom_range(0, 11),
                 $urandom_range(0, 11), $urandom_range(0, 11));
         ep = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
         if ($urandom_range(0, 199) == 0)
            async_reset("rnd_rst");
         else
            step("rnd", ep, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/time_setter.md
Name: time_setter

Overview:
- Edit-side writer for the clock display path. Produces the set flag and the four BCD preset digits (HH:MM) that the display selector shows while the user edits the time.
- When the user confirms, it issues a one-cycle load pulse so the time counter takes the edited value.
- Sits between the debounced push-button pulse generators and the counter/display-selector pair, in the same clock domain.

Parameters:
- HOUR_MAX, 23, highest legal hour value; hour wraps HOUR_MAX<->0.
- MIN_MAX, 59, highest legal minute value; minute wraps MIN_MAX<->0.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- en_pause  input  2  run/pause control; editing is permitted only while en_pause==2'b01.
- btn_mode  input  1  one-cycle debounced pulse; enter edit / advance field / confirm.
- btn_inc  input  1  one-cycle debounced pulse; increment the selected field.
- btn_dec  input  1  one-cycle debounced pulse; decrement the selected field.
- cur_h1, cur_h0, cur_m1, cur_m0  input  4 each  live BCD time digits from the counter.
- set  output  1  high while editing; selects the preset digits for display.
- init_value_h1, init_value_h0, init_value_m1, init_value_m0  output  4 each  edited BCD digits.
- load  output  1  one-cycle pulse; counter loads the init_value_* digits.
- field  output  1  selected field: 0=hour, 1=minute. Used for display blink.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, set=0, load=0, field=0, all init_value_*=4'd0.
- All outputs are registered. Button effects are visible 1 cycle after the pulse cycle.
- States: IDLE, EDIT_H, EDIT_M, COMMIT.
- IDLE: set=0. On btn_mode with en_pause==2'b01:
  - capture cur_h1..cur_m0 into init_value_*;
  - go to EDIT_H; set=1, field=0.
  - btn_mode with any other en_pause is ignored. inc/dec are ignored in IDLE.
- EDIT_H: btn_inc/btn_dec change the hour (init_value_h1:h0) as a decimal 0..HOUR_MAX value. btn_mode goes to EDIT_M with field=1.
- EDIT_M: btn_inc/btn_dec change the minute (init_value_m1:m0) as 0..MIN_MAX. btn_mode goes to COMMIT.
- COMMIT: lasts exactly one cycle. load=1 and set stays 1 in this cycle so the displayed value does not glitch. Next cycle: IDLE, set=0, load=0. init_value_* hold their last values.
- Arithmetic is two-digit BCD per field:
  - inc: units digit 9 -> 0 with carry into tens.
  - value == max on inc -> 00.
  - value 00 on dec -> max.
  - dec: units digit 0 -> 9 with borrow from tens.
  - Examples: hour 09 -> 10; 19 -> 20; 23 -> 00. Minute 59 -> 00; 00 dec -> 59; 10 dec -> 09.
- Out-of-range captured values (e.g. hour 25, or a non-BCD digit > 9): inc -> 00, dec -> max. The value is never left out of range after an edit.
- Simultaneous pulses: btn_mode has priority; inc/dec in the same cycle are dropped. If inc and dec arrive together without mode, neither is applied and the value is unchanged.
- Abort: if en_pause != 2'b01 in EDIT_H or EDIT_M, go to IDLE next cycle with set=0 and no load pulse. Abort has priority over all buttons.
- COMMIT always completes; load fires even if en_pause changes in that cycle.
- Reset mid-edit: immediate return to reset values; no load pulse.

Test Plan:
- Reset: assert rst mid-EDIT_M -> set=0, load=0, field=0, all init_value_*=0 without waiting for a clock edge.
- Capture and commit: cur=12:34, en_pause=01, then mode, mode, mode -> init_value_*=1,2,3,4; set high for 3 cycles; load high exactly 1 cycle, coincident with the last set cycle.
- Hour wrap: capture 22:00, in EDIT_H apply inc x2 -> 23 then 00; dec once -> 23; from 09 apply inc -> 10.
- Minute wrap: in EDIT_M from 59 apply inc -> 00; dec -> 59; from 10 apply dec -> 09.
- Abort: in EDIT_H set en_pause=2'b10 -> set=0 next cycle, load never pulses, state IDLE.
- Priority: in EDIT_H assert mode+inc in the same cycle -> field=1, hour unchanged. Assert inc+dec together -> value unchanged. In IDLE with en_pause=00, press mode -> set stays 0.
